// File: rtl/pito_pkg.sv
// Shared pito SoC definitions: APB widths and the APB arbiter state encoding.
package pito_pkg;

   localparam int APB_ADDR_WIDTH  = 32;
   localparam int APB_DATA_WIDTH  = 32;

   // Default number of ACCESS cycles the arbiter waits for pready before it
   // gives up and reports an error to the requester.
   localparam int APB_ARB_TIMEOUT = 256;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } apb_arb_state_e;

endpackage

// File: rtl/pito_rr_picker.sv
// Combinational round-robin search: first eligible bit at or above rr_ptr_i,
// wrapping modulo NUM_REQ.
module pito_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   // cand_idx[k] is the requester visited k steps after rr_ptr_i.
   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         // One extra bit so ptr+offset cannot overflow before the wrap.
         assign sum           = {1'b0, rr_ptr_i} + (IDX_W+1)'(gi);
         assign cand_idx[gi]  = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W)
                                                   : sum[IDX_W-1:0];
         assign cand_hit[gi]  = eligible_i[cand_idx[gi]];
      end
   endgenerate

   // Priority by distance from the pointer: the smallest offset is assigned last and wins.
   always_comb begin
      valid_o = |cand_hit;
      idx_o   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            idx_o = cand_idx[i];
         end
      end
   end

endmodule

// File: rtl/pito_apb_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ
// requesters using a level req / one-cycle done handshake, with a timeout
// for slaves that never raise pready.
module pito_apb_arbiter
   import pito_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            req_write_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          err_o,
   output logic [ADDR_WIDTH-1:0]         paddr_o,
   output logic                          pwrite_o,
   output logic [DATA_WIDTH-1:0]         pwdata_o,
   output logic                          psel_o,
   output logic                          penable_o,
   input  logic [DATA_WIDTH-1:0]         prdata_i,
   input  logic                          pready_i,
   input  logic                          pslverr_i,
   output logic                          busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   apb_arb_state_e          state_q,  state_d;
   logic [IDX_W-1:0]        grant_q,  grant_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0]   paddr_q,  paddr_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [NUM_REQ-1:0]      done_q,   done_d;
   logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
   logic                    err_q,    err_d;
   logic [TMO_W-1:0]        tmo_q,    tmo_d;

   // Per-requester views of the packed payload buses.
   logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr_i [gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // A requester whose done pulse is on the bus this cycle is still holding
   // req high; masking it stops it being re-granted for a finished transfer.
   logic [NUM_REQ-1:0] eligible;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;

   assign eligible = req_i & ~done_q;

   pito_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .eligible_i (eligible),
      .rr_ptr_i   (rr_ptr_q),
      .valid_o    (pick_valid),
      .idx_o      (pick_idx)
   );

   // Next requester after the one just served, wrapping at NUM_REQ.
   logic [IDX_W-1:0] rr_after_grant;
   assign rr_after_grant = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

   // Next-state logic: grant in IDLE, fixed SETUP, ACCESS until pready or timeout.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      tmo_d    = tmo_q;
      // Completion status is a single-cycle pulse, so it defaults to zero.
      done_d   = '0;
      rdata_d  = '0;
      err_d    = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            tmo_d = '0;
            if (pick_valid) begin
               grant_d  = pick_idx;
               paddr_d  = addr_arr[pick_idx];
               pwrite_d = req_write_i[pick_idx];
               pwdata_d = wdata_arr[pick_idx];
               state_d  = ARB_SETUP;
            end
         end

         ARB_SETUP: begin
            tmo_d   = '0;
            state_d = ARB_ACCESS;
         end

         ARB_ACCESS: begin
            if (pready_i) begin
               done_d[grant_q] = 1'b1;
               rdata_d         = pwrite_q ? '0 : prdata_i;
               err_d           = pslverr_i;
               rr_ptr_d        = rr_after_grant;
               tmo_d           = '0;
               state_d         = ARB_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               // The slave has had TIMEOUT_CYCLES ACCESS cycles; release the bus.
               done_d[grant_q] = 1'b1;
               err_d           = 1'b1;
               rr_ptr_d        = rr_after_grant;
               tmo_d           = '0;
               state_d         = ARB_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops the bus and discards any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         done_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign psel_o    = (state_q != ARB_IDLE);
   assign penable_o = (state_q == ARB_ACCESS);
   assign busy_o    = (state_q != ARB_IDLE);
   assign paddr_o   = paddr_q;
   assign pwrite_o  = pwrite_q;
   assign pwdata_o  = pwdata_q;
   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_pito_apb_arbiter.sv
// Self-checking bench for pito_apb_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level reference model.
module tb_pito_apb_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_i, req_write_i;
   logic [N*AW-1:0] req_addr_i;
   logic [N*DW-1:0] req_wdata_i;
   logic [N-1:0]    done_o;
   logic [DW-1:0]   rdata_o;
   logic            err_o;
   logic [AW-1:0]   paddr_o;
   logic            pwrite_o;
   logic [DW-1:0]   pwdata_o;
   logic            psel_o, penable_o;
   logic [DW-1:0]   prdata_i;
   logic            pready_i, pslverr_i;
   logic            busy_o;

   pito_apb_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
      .pwdata_o(pwdata_o), .psel_o(psel_o), .penable_o(penable_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: m_age counts cycles since the grant (0 = no transfer),
   // so ACCESS cycle number is m_age-1.
   int            m_age   = 0;
   int            m_g     = 0;
   int            m_ptr   = 0;
   int            m_wait  = 0;
   logic [AW-1:0] m_addr  = '0;
   logic          m_write = 1'b0;
   logic [DW-1:0] m_wdata = '0;
   logic [N-1:0]  exp_done  = '0;
   logic [DW-1:0] exp_rdata = '0;
   logic          exp_err   = 1'b0;

   // Scenario controls: -1 means randomize.
   bit            rand_mode     = 1'b0;
   int            dir_wait      = 0;
   int            dir_err       = 0;
   bit            use_dir_rdata = 1'b0;
   logic [DW-1:0] dir_rdata     = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("psel",    64'(psel_o),    64'(m_age >= 1));
      chk("penable", 64'(penable_o), 64'(m_age >= 2));
      chk("busy",    64'(busy_o),    64'(m_age >= 1));
      chk("done",    64'(done_o),    64'(exp_done));
      chk("paddr",   64'(paddr_o),   64'(m_addr));
      chk("pwrite",  64'(pwrite_o),  64'(m_write));
      chk("pwdata",  64'(pwdata_o),  64'(m_wdata));
      if (exp_done != '0) begin
         chk("rdata", 64'(rdata_o), 64'(exp_rdata));
         chk("err",   64'(err_o),   64'(exp_err));
         $display("txn done=%b addr=0x%08h write=%0d rdata=0x%08h err=%0d",
                  done_o, m_addr, m_write, rdata_o, err_o);
      end
   endtask

   task automatic set_req(input int k, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_write_i[k]           = w;
      req_addr_i[k*AW +: AW]   = a;
      req_wdata_i[k*DW +: DW]  = d;
      req_i[k]                 = 1'b1;
   endtask

   task automatic drive_requesters();
      for (int k = 0; k < N; k++) begin
         if (!req_i[k]) begin
            if ($urandom_range(0, 3) == 0) set_req(k, 1'($urandom), $urandom, $urandom);
         end else if (exp_done[k]) begin
            if ($urandom_range(0, 1) == 0) req_i[k] = 1'b0;
            else set_req(k, 1'($urandom), $urandom, $urandom);
         end else if (m_age > 0 && m_g == k) begin
            // Payload scribbles and req drops after grant must not affect the transfer.
            if ($urandom_range(0, 7) == 0) set_req(k, 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 15) == 0) req_i[k] = 1'b0;
         end
      end
   endtask

   task automatic drive_slave();
      if (m_age >= 2) pready_i = ((m_age - 2) == m_wait);
      else            pready_i = 1'($urandom);
      prdata_i  = use_dir_rdata ? dir_rdata : DW'($urandom);
      pslverr_i = (dir_err >= 0) ? dir_err[0] : ($urandom_range(0, 3) == 0);
   endtask

   task automatic model_step();
      logic [N-1:0] nd;
      logic [N-1:0] elig;
      int           idx;
      bit           found;
      if (rst) begin
         m_age = 0; m_ptr = 0; m_addr = '0; m_write = 1'b0; m_wdata = '0;
         exp_done = '0; exp_rdata = '0; exp_err = 1'b0;
         return;
      end
      nd = '0;
      if (m_age == 0) begin
         elig  = req_i & ~exp_done;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && elig[idx]) begin
               found   = 1'b1;
               m_g     = idx;
               m_addr  = req_addr_i[idx*AW +: AW];
               m_write = req_write_i[idx];
               m_wdata = req_wdata_i[idx*DW +: DW];
               m_age   = 1;
               if (dir_wait >= 0) m_wait = dir_wait;
               else if ($urandom_range(0, 7) == 0) m_wait = $urandom_range(T, T + 4);
               else m_wait = $urandom_range(0, 3);
            end
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (pready_i) begin
         nd[m_g]   = 1'b1;
         exp_rdata = m_write ? '0 : prdata_i;
         exp_err   = pslverr_i;
         m_ptr     = (m_g + 1) % N;
         m_age     = 0;
      end else if (m_age - 1 == T) begin
         nd[m_g]   = 1'b1;
         exp_rdata = '0;
         exp_err   = 1'b1;
         m_ptr     = (m_g + 1) % N;
         m_age     = 0;
      end else begin
         m_age++;
      end
      exp_done = nd;
   endtask

   // One clock: inputs for this cycle are final, model advances, outputs are checked.
   task automatic cycle();
      if (rand_mode) drive_requesters();
      drive_slave();
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_done(output int idx, input int budget);
      idx = -1;
      for (int c = 0; c < budget && idx < 0; c++) begin
         cycle();
         for (int k = 0; k < N; k++) if (done_o[k]) idx = k;
      end
      if (idx < 0) chk("done_wait_expired", 64'(0), 64'(1));
   endtask

   initial begin
      int idx, pen_cnt, n_rr, guard;
      int order [12];
      int cnt   [N];

      rst = 1'b1; req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
      prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      chk("reset_psel", 64'(psel_o), 64'(0));
      chk("reset_done", 64'(done_o), 64'(0));
      chk("reset_paddr", 64'(paddr_o), 64'(0));

      // Single zero-wait read by requester 1.
      dir_wait = 0; dir_err = 0; use_dir_rdata = 1'b1; dir_rdata = 32'hDEAD_BEEF;
      set_req(1, 1'b0, 32'h0000_0040, 32'h0);
      cycle();
      chk("rd_setup_psel", 64'(psel_o), 64'(1));
      chk("rd_setup_penable", 64'(penable_o), 64'(0));
      cycle();
      chk("rd_access_penable", 64'(penable_o), 64'(1));
      cycle();
      chk("rd_done", 64'(done_o), 64'(4'b0010));
      chk("rd_rdata", 64'(rdata_o), 64'(32'hDEAD_BEEF));
      chk("rd_err", 64'(err_o), 64'(0));
      req_i = '0;

      // Round robin from a freshly reset pointer.
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int k = 0; k < N; k++) begin
         cnt[k] = 0;
         set_req(k, 1'b0, 32'h100 + 32'(k), 32'h0);
      end
      n_rr = 0; guard = 0;
      while (n_rr < 12 && guard < 400) begin
         cycle(); guard++;
         for (int k = 0; k < N; k++) begin
            if (done_o[k]) begin
               order[n_rr] = k; n_rr++; cnt[k]++;
               chk("rr_idle_psel", 64'(psel_o), 64'(0));
               if (cnt[k] == 3) req_i[k] = 1'b0;
            end
         end
      end
      chk("rr_count", 64'(n_rr), 64'(12));
      for (int i = 0; i < n_rr; i++) chk("rr_order", 64'(order[i]), 64'(i % 4));
      req_i = '0;

      // Write with five wait states and a slave error.
      dir_wait = 5; dir_err = 1;
      set_req(0, 1'b1, 32'h0000_0010, 32'h1234_5678);
      pen_cnt = 0; idx = -1;
      for (int c = 0; c < 40 && idx < 0; c++) begin
         cycle();
         if (penable_o) pen_cnt++;
         if (psel_o) chk("ws_pwdata", 64'(pwdata_o), 64'(32'h1234_5678));
         if (done_o != '0) begin
            idx = 0;
            chk("ws_done", 64'(done_o), 64'(4'b0001));
            chk("ws_err", 64'(err_o), 64'(1));
         end
      end
      chk("ws_penable_cycles", 64'(pen_cnt), 64'(6));
      req_i = '0;

      // Timeout: the slave never answers.
      dir_wait = 100; dir_err = 0; dir_rdata = 32'h5555_AAAA;
      set_req(2, 1'b0, 32'h0000_0020, 32'h0);
      pen_cnt = 0; idx = -1;
      for (int c = 0; c < 40 && idx < 0; c++) begin
         cycle();
         if (penable_o) pen_cnt++;
         if (done_o != '0) begin
            idx = 0;
            chk("to_done", 64'(done_o), 64'(4'b0100));
            chk("to_err", 64'(err_o), 64'(1));
            chk("to_rdata", 64'(rdata_o), 64'(0));
         end
      end
      chk("to_penable_cycles", 64'(pen_cnt), 64'(T));
      req_i = '0;
      dir_wait = 0; dir_rdata = 32'hA5A5_0F0F;
      set_req(1, 1'b0, 32'h0000_0024, 32'h0);
      wait_done(idx, 20);
      chk("post_to_grant", 64'(idx), 64'(1));
      chk("post_to_rdata", 64'(rdata_o), 64'(32'hA5A5_0F0F));
      req_i = '0;

      // Reset during the second ACCESS cycle; pointer is 2 before the reset.
      dir_wait = 100;
      set_req(1, 1'b0, 32'h0000_0030, 32'h0);
      for (int c = 0; c < 10 && !penable_o; c++) cycle();
      cycle();
      chk("rst_2nd_access", 64'(penable_o), 64'(1));
      rst = 1'b1; req_i[1] = 1'b0;
      set_req(2, 1'b0, 32'h0000_0200, 32'h0);
      set_req(0, 1'b0, 32'h0000_0000, 32'h0);
      dir_wait = 0;
      cycle();
      chk("rst_psel", 64'(psel_o), 64'(0));
      chk("rst_penable", 64'(penable_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      rst = 1'b0;
      wait_done(idx, 20);
      chk("rst_first_grant", 64'(idx), 64'(0));
      req_i[0] = 1'b0;
      wait_done(idx, 20);
      chk("rst_second_grant", 64'(idx), 64'(2));
      req_i[2] = 1'b0;

      // Requester 3 re-requests in its done cycle while requester 0 arrives.
      set_req(3, 1'b0, 32'h0000_0300, 32'h0);
      wait_done(idx, 20);
      chk("sim_first", 64'(idx), 64'(3));
      set_req(0, 1'b1, 32'h0000_0004, 32'hCAFE_0000);
      set_req(3, 1'b1, 32'h0000_0304, 32'hCAFE_0003);
      wait_done(idx, 20);
      chk("sim_next_is_0", 64'(idx), 64'(0));
      req_i[0] = 1'b0;
      wait_done(idx, 20);
      chk("sim_then_3", 64'(idx), 64'(3));
      req_i = '0;

      // Randomized traffic with variable wait states, errors and timeouts.
      rand_mode = 1'b1; dir_wait = -1; dir_err = -1; use_dir_rdata = 1'b0;
      repeat (2000) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
